ucore_port_fifo: RTL and testbench
==================================

# ucore_port_fifo

Output-port buffer placed directly downstream of a generated `ucore_<name>` core. It captures single-cycle write strobes that the core's FSM issues on an output port and presents them as a valid/ready stream to the consuming logic. It returns a `full` flag so the core's program can poll it and stall before writing.

## Interface

Parameters:
- `WIDTH`, 32: data width of the captured output port, in bits.
- `DEPTH`, 8: number of storage entries. Must be a power of two and at least 2.

Ports:
- `clk`, in, 1: global clock. All state updates on the rising edge.
- `areset`, in, 1: asynchronous, active-high reset. Takes effect immediately on assertion; release is synchronous to `clk`.
- `wr_en`, in, 1: write strobe from the ucore output port.
- `wr_data`, in, `WIDTH`: data written by the core. Sampled when `wr_en=1`.
- `full`, out, 1: high when the FIFO holds `DEPTH` entries. Registered.
- `m_valid`, out, 1: high when the FIFO holds at least one entry.
- `m_data`, out, `WIDTH`: head entry. Driven to 0 whenever `m_valid=0`.
- `m_ready`, in, 1: consumer accepts the head entry.
- `overflow`, out, 1: sticky flag. Set when a write is dropped.
- `level`, out, clog2(`DEPTH`)+1: current occupancy. Present only with `UCORE_PORT_FIFO_LEVEL_EN`.

## Operation

- Storage: `DEPTH` × `WIDTH` register array.
- Pointers: write and read pointers, each clog2(`DEPTH`)+1 bits wide. The MSB is a wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2·`DEPTH`.
- Push: `wr_en && !full`. Writes `wr_data` at the write pointer, then the write pointer increments.
- Pop: `m_valid && m_ready`. The read pointer increments.
- Dropped write: `wr_en && full`.
  - Data is discarded and pointers are unchanged.
  - `overflow` is set to 1 and held until reset.
  - This applies even if a pop occurs in the same cycle. `full` is evaluated from the registered state before the edge, so a same-cycle pop does not make room for the write.
- Simultaneous push and pop when not full and not empty: both occur, and occupancy is unchanged.
- Push when empty: the entry becomes visible on the next cycle. There is no same-cycle bypass.
- `m_ready` while `m_valid=0`: ignored.
- Data ordering: strict FIFO. No entry is ever duplicated or reordered.
- Reset values: all pointers 0, `full=0`, `m_valid=0`, `m_data=0`, `overflow=0`, `level=0`. Storage contents are not reset.
- Reset mid-operation: all buffered entries are discarded immediately. Outputs take their reset values asynchronously.

## Timing

- Write-to-visible latency: 1 cycle. If a push occurs at edge N, `m_valid=1` and `m_data=wr_data` during the cycle after edge N.
- `full` updates at the edge that completes the `DEPTH`th push.
- `full` deasserts at the edge of the first pop from the full state. A write in the following cycle is accepted.
- `m_valid` and `m_data` are decoded from registered pointers and storage. There is no combinational path from `m_ready` to `m_valid` or `m_data`.
- There is no combinational path from `wr_en` to `full`.
- Throughput: one push and one pop per cycle, sustained.

## Configuration

- `UCORE_PORT_FIFO_LEVEL_EN` defined:
  - The `level` port exists.
  - It is the registered occupancy: write pointer minus read pointer, modulo 2·`DEPTH`.
  - Range 0..`DEPTH`. Updates at the same edge as the pointers.
- `UCORE_PORT_FIFO_LEVEL_EN` undefined:
  - The `level` port and its logic are absent.
  - All other behaviour is identical.

## Test plan

- Fill: `DEPTH=8`, `m_ready=0`, 8 writes of 0x11..0x18.
  - `full=1` after the 8th edge. `overflow=0`. `level=8`.
  - A 9th write of 0x19 is dropped: `overflow=1`, and `level` stays 8.
- Drain: from the filled state above, `m_ready=1`.
  - `m_data` sequence is 0x11..0x18 on consecutive cycles.
  - `m_valid=0` and `m_data=0` afterwards.
  - `full` is 0 from the first pop onward.
- Steady state: with 3 entries, assert push and pop every cycle for 20 cycles.
  - `level` stays 3.
  - Output order matches input order across pointer wrap-around.
- Push while full with same-cycle pop: with 8 entries, `wr_en=1`, `wr_data=0xAA`, `m_ready=1`.
  - 0xAA is dropped and `overflow=1`.
  - The next write of 0xBB is accepted and appears after the remaining 7 entries.
- Reset mid-stream: with 5 entries and `overflow=1`, pulse `areset` between clock edges.
  - `m_valid=0`, `full=0`, `overflow=0`, `level=0` immediately.
  - After release, a write of 0x42 appears on `m_data` one cycle later.

Source files
------------

// File: rtl/ucore_port_fifo_if.sv
// Stream bundle between a ucore output port, its buffer and the consumer.
// The level signal exists only when UCORE_PORT_FIFO_LEVEL_EN is defined.
interface ucore_port_fifo_if #(
    parameter int WIDTH = 32
`ifdef UCORE_PORT_FIFO_LEVEL_EN
    , parameter int DEPTH = 8
`endif
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             overflow;
`ifdef UCORE_PORT_FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] level;

    modport master (output wr_en, wr_data, m_ready,
                    input  full, m_valid, m_data, overflow, level);
    modport slave  (input  wr_en, wr_data, m_ready,
                    output full, m_valid, m_data, overflow, level);
`else
    modport master (output wr_en, wr_data, m_ready,
                    input  full, m_valid, m_data, overflow);
    modport slave  (input  wr_en, wr_data, m_ready,
                    output full, m_valid, m_data, overflow);
`endif
endinterface

// File: rtl/ucore_port_fifo.sv
// Output-port FIFO: turns ucore write strobes into a valid/ready stream.
// Optional occupancy output enabled by defining UCORE_PORT_FIFO_LEVEL_EN.
module ucore_port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                areset,
    ucore_port_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_full;
    logic             r_overflow;

    logic [AW:0]      w_wptr_nxt;
    logic [AW:0]      w_rptr_nxt;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full_nxt;

    // full comes from the pre-edge state, so a same-cycle pop never frees room
    assign w_valid    = (r_wptr != r_rptr);
    assign w_push     = bus.wr_en && !r_full;
    assign w_drop     = bus.wr_en && r_full;
    assign w_pop      = w_valid && bus.m_ready;
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};
    assign w_full_nxt = (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]) &&
                        (w_wptr_nxt[AW] != w_rptr_nxt[AW]);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_full <= w_full_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= bus.wr_data;
        end
    end

    assign bus.full     = r_full;
    assign bus.m_valid  = w_valid;
    assign bus.m_data   = w_valid ? r_mem[r_rptr[AW-1:0]] : '0;
    assign bus.overflow = r_overflow;

`ifdef UCORE_PORT_FIFO_LEVEL_EN
    assign bus.level = r_wptr - r_rptr;
`endif
endmodule

// File: tb/tb_ucore_port_fifo.sv
// Randomized and directed bench for ucore_port_fifo against a queue model.
module tb_ucore_port_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic areset = 1'b1;

`ifdef UCORE_PORT_FIFO_LEVEL_EN
    ucore_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();
`else
    ucore_port_fifo_if #(.WIDTH(WIDTH)) bus();
`endif

    ucore_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] q[$];
    logic m_ovf = 1'b0;

    // Drive one cycle of stimulus and advance the model across the edge.
    task automatic cyc(input logic we, input logic [WIDTH-1:0] wd, input logic rdy);
        bit was_full;
        bus.wr_en = we; bus.wr_data = wd; bus.m_ready = rdy;
        @(posedge clk);
        was_full = (q.size() == DEPTH);
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (we && !was_full) q.push_back(wd);
        if (we && was_full) m_ovf = 1'b1;
        #1;
        bus.wr_en = 1'b0; bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", bus.m_valid); end
        n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %0b want 0", bus.full); end
        n_cmp++; if (bus.m_data !== '0) begin n_bad++; $display("FAIL rst_data got %h want 0", bus.m_data); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %0b want 0", bus.overflow); end
`ifdef UCORE_PORT_FIFO_LEVEL_EN
        n_cmp++; if (bus.level !== 4'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", bus.level); end
`endif
        areset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, WIDTH'(32'h11 + i), 1'b0);
            n_cmp++; if (bus.full !== (i == DEPTH - 1)) begin n_bad++; $display("FAIL fill_full[%0d] got %0b want %0b", i, bus.full, i == DEPTH - 1); end
            n_cmp++; if (bus.m_data !== 32'h11) begin n_bad++; $display("FAIL fill_head[%0d] got %h want 11", i, bus.m_data); end
        end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL fill_ovf got %0b want 0", bus.overflow); end
`ifdef UCORE_PORT_FIFO_LEVEL_EN
        n_cmp++; if (bus.level !== 4'd8) begin n_bad++; $display("FAIL fill_level got %0d want 8", bus.level); end
`endif
        cyc(1'b1, 32'h19, 1'b0);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL drop_ovf got %0b want 1", bus.overflow); end
        n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL drop_full got %0b want 1", bus.full); end
`ifdef UCORE_PORT_FIFO_LEVEL_EN
        n_cmp++; if (bus.level !== 4'd8) begin n_bad++; $display("FAIL drop_level got %0d want 8", bus.level); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== WIDTH'(32'h11 + i))
                begin n_bad++; $display("FAIL drain[%0d] got v=%0b d=%h want v=1 d=%h", i, bus.m_valid, bus.m_data, 32'h11 + i); end
            cyc(1'b0, '0, 1'b1);
            n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL drain_full[%0d] got %0b want 0", i, bus.full); end
        end
        n_cmp++; if (bus.m_valid !== 1'b0 || bus.m_data !== '0)
            begin n_bad++; $display("FAIL drain_empty got v=%0b d=%h want v=0 d=0", bus.m_valid, bus.m_data); end
    endtask

    task automatic test_steady();
        for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, WIDTH'($urandom), 1'b1);
            n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== q[0])
                begin n_bad++; $display("FAIL steady_head[%0d] got v=%0b d=%h want v=1 d=%h", i, bus.m_valid, bus.m_data, q[0]); end
`ifdef UCORE_PORT_FIFO_LEVEL_EN
            n_cmp++; if (bus.level !== 4'd3) begin n_bad++; $display("FAIL steady_level[%0d] got %0d want 3", i, bus.level); end
`endif
        end
        n_cmp++; if (q.size() != 3) begin n_bad++; $display("FAIL steady_occupancy got %0d want 3", q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.m_data !== q[0]) begin n_bad++; $display("FAIL steady_tail[%0d] got %h want %h", i, bus.m_data, q[0]); end
            cyc(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cyc(1'b1, WIDTH'($urandom), 1'b0);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL mid_pre_ovf got %0b want 1", bus.overflow); end
        #2 areset = 1'b1;
        #1;
        q.delete(); m_ovf = 1'b0;
        n_cmp++; if (bus.m_valid !== 1'b0 || bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.m_data !== '0)
            begin n_bad++; $display("FAIL mid_rst got v=%0b f=%0b o=%0b d=%h want all 0", bus.m_valid, bus.full, bus.overflow, bus.m_data); end
`ifdef UCORE_PORT_FIFO_LEVEL_EN
        n_cmp++; if (bus.level !== 4'd0) begin n_bad++; $display("FAIL mid_level got %0d want 0", bus.level); end
`endif
        #1 areset = 1'b0;
        @(posedge clk); #1;
        cyc(1'b1, 32'h42, 1'b0);
        n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h42)
            begin n_bad++; $display("FAIL mid_after got v=%0b d=%h want v=1 d=42", bus.m_valid, bus.m_data); end
        cyc(1'b0, '0, 1'b1);
    endtask

    task automatic test_full_pop();
        logic [WIDTH-1:0] last;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, WIDTH'($urandom), 1'b0);
        cyc(1'b1, 32'hAA, 1'b1);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL fp_ovf got %0b want 1", bus.overflow); end
        n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL fp_full got %0b want 0", bus.full); end
        cyc(1'b1, 32'hBB, 1'b0);
        n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL fp_refill got %0b want 1", bus.full); end
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (bus.m_data !== q[0]) begin n_bad++; $display("FAIL fp_order[%0d] got %h want %h", i, bus.m_data, q[0]); end
            last = bus.m_data;
            cyc(1'b0, '0, 1'b1);
        end
        n_cmp++; if (last !== 32'hBB || bus.m_valid !== 1'b0)
            begin n_bad++; $display("FAIL fp_last got d=%h v=%0b want d=bb v=0", last, bus.m_valid); end
    endtask

    task automatic test_random();
        int pw;
        for (int i = 0; i < 400; i++) begin
            pw = ((i / 50) % 2 == 0) ? 80 : 30;
            cyc(($urandom_range(0, 99) < pw), WIDTH'($urandom), ($urandom_range(0, 99) < 100 - pw));
            n_cmp++; if (bus.m_valid !== (q.size() != 0) || bus.m_data !== ((q.size() != 0) ? q[0] : '0))
                begin n_bad++; $display("FAIL rnd_head[%0d] got v=%0b d=%h want v=%0b d=%h", i, bus.m_valid, bus.m_data, q.size() != 0, (q.size() != 0) ? q[0] : '0); end
            n_cmp++; if (bus.full !== (q.size() == DEPTH) || bus.overflow !== m_ovf)
                begin n_bad++; $display("FAIL rnd_flags[%0d] got f=%0b o=%0b want f=%0b o=%0b", i, bus.full, bus.overflow, q.size() == DEPTH, m_ovf); end
`ifdef UCORE_PORT_FIFO_LEVEL_EN
            n_cmp++; if (bus.level !== 4'(q.size())) begin n_bad++; $display("FAIL rnd_level[%0d] got %0d want %0d", i, bus.level, q.size()); end
`endif
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.m_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_steady();
        test_reset_mid();
        test_full_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
